fft16_output_reorder: RTL

- Output stage directly downstream of the four radix-4 linear-combination butterflies (types A/B/C/D) of the 16-point FFT.
- Each butterfly group delivers four complex IEEE-754 single-precision results at once. This block captures four groups per frame (16 bins) into a ping-pong buffer.
- It then streams the bins out serially in natural order, one complex word per clock.
- Data words are opaque; the block does no arithmetic on them.

---
 rtl/fft16_pkg.sv | 26 ++
 rtl/fft16_output_reorder_if.sv | 30 +++
 rtl/fft16_reorder_bank.sv | 40 ++++
 rtl/fft16_output_reorder.sv | 101 ++++++++++
 4 files changed

// File: rtl/fft16_pkg.sv
// Shared constants, types and address helper for the 16-point FFT output reorder stage.
package fft16_pkg;

    localparam int DATA_W   = 32;
    localparam int N_POINTS = 16;
    localparam int RADIX    = 4;
    localparam int ADDR_W   = $clog2(N_POINTS);

    localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(N_POINTS - 1);

    typedef struct packed {
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
    } cplx_t;

    typedef enum logic {
        IDLE,
        STREAM
    } rd_state_e;

    // Lane l of group g holds bin 4*l+g.
    function automatic logic [ADDR_W-1:0] digit_rev4(input logic [1:0] l, input logic [1:0] g);
        return {l, g};
    endfunction

endpackage

// File: rtl/fft16_output_reorder_if.sv
// Butterfly-group input bus and serial bin output bus of the reorder stage.
interface fft16_output_reorder_if;
    import fft16_pkg::*;

    logic              in_valid;
    logic              in_frame_start;
    logic [DATA_W-1:0] in0_real, in0_im;
    logic [DATA_W-1:0] in1_real, in1_im;
    logic [DATA_W-1:0] in2_real, in2_im;
    logic [DATA_W-1:0] in3_real, in3_im;

    logic              out_valid;
    logic [DATA_W-1:0] out_real, out_im;
    logic [ADDR_W-1:0] out_index;
    logic              out_last;
    logic              overflow;

    modport master (
        output in_valid, in_frame_start,
        output in0_real, in0_im, in1_real, in1_im, in2_real, in2_im, in3_real, in3_im,
        input  out_valid, out_real, out_im, out_index, out_last, overflow
    );

    modport slave (
        input  in_valid, in_frame_start,
        input  in0_real, in0_im, in1_real, in1_im, in2_real, in2_im, in3_real, in3_im,
        output out_valid, out_real, out_im, out_index, out_last, overflow
    );

endinterface

// File: rtl/fft16_reorder_bank.sv
// Ping-pong frame store: four same-cycle lane writes, one registered read, bank chosen per side.
module fft16_reorder_bank
    import fft16_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic              wr_bank_i,
    input  logic [1:0]        wr_group_i,
    input  cplx_t             wr_data_i [RADIX],
    input  logic              rd_en_i,
    input  logic              rd_bank_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output cplx_t             rd_data_o
);

    cplx_t mem_q [2][N_POINTS];
    cplx_t rd_data_q;

    // NOTE: the storage array is deliberately left out of reset so it maps onto plain RAM;
    // every bin is rewritten before a bank is ever read.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int l = 0; l < RADIX; l++) begin
                mem_q[wr_bank_i][digit_rev4(2'(l), wr_group_i)] <= wr_data_i[l];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_bank_i][rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fft16_output_reorder.sv
// Captures four butterfly groups per frame into a ping-pong store and streams bins 0..15 serially.
module fft16_output_reorder
    import fft16_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    fft16_output_reorder_if.slave bus
);

    logic [1:0]        group_q;
    logic              wr_bank_q;
    rd_state_e         state_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic              rd_bank_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic [ADDR_W-1:0] out_index_q;
    logic              overflow_q;

    logic [1:0] wr_group;
    logic       issue;
    logic       complete;
    logic       accept;
    cplx_t      lane_data [RADIX];
    cplx_t      rd_data;

    // A frame-start group always lands as group 0, dropping any partial frame.
    assign wr_group = bus.in_frame_start ? 2'd0 : group_q;
    assign issue    = (state_q == STREAM);
    assign complete = bus.in_valid && (wr_group == 2'd3);
    // The edge that issues bin 15 may hand straight over to the next frame.
    assign accept   = complete && (!issue || rd_ptr_q == LAST_BIN);

    assign lane_data[0] = {bus.in0_real, bus.in0_im};
    assign lane_data[1] = {bus.in1_real, bus.in1_im};
    assign lane_data[2] = {bus.in2_real, bus.in2_im};
    assign lane_data[3] = {bus.in3_real, bus.in3_im};

    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            group_q     <= 2'd0;
            wr_bank_q   <= 1'b0;
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            rd_bank_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_index_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            if (bus.in_valid) begin
                group_q <= wr_group + 2'd1;
            end

            out_valid_q <= issue;
            out_last_q  <= issue && (rd_ptr_q == LAST_BIN);
            if (issue) begin
                out_index_q <= rd_ptr_q;
            end

            if (accept) begin
                wr_bank_q <= ~wr_bank_q;
                rd_bank_q <= wr_bank_q;
                rd_ptr_q  <= '0;
                state_q   <= STREAM;
            end else begin
                if (complete) begin
                    overflow_q <= 1'b1;
                end
                if (issue) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                    if (rd_ptr_q == LAST_BIN) begin
                        state_q <= IDLE;
                    end
                end
            end
        end
    end

    fft16_reorder_bank u_bank (
        .clk        (clk),
        .reset      (reset),
        .wr_en_i    (bus.in_valid),
        .wr_bank_i  (wr_bank_q),
        .wr_group_i (wr_group),
        .wr_data_i  (lane_data),
        .rd_en_i    (issue),
        .rd_bank_i  (rd_bank_q),
        .rd_addr_i  (rd_ptr_q),
        .rd_data_o  (rd_data)
    );

    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_index = out_index_q;
    assign bus.overflow  = overflow_q;
    assign bus.out_real  = rd_data.re;
    assign bus.out_im    = rd_data.im;

endmodule
